// File: rtl/rect_plot_pkg.sv
// rtl/rect_plot_pkg.sv - shared state encoding, screen limits and default field widths
package rect_plot_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SCAN = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int SCREEN_W  = 160;
  localparam int SCREEN_H  = 120;
  localparam int DEF_X_W   = 8;
  localparam int DEF_Y_W   = 7;
  localparam int DEF_COL_W = 3;
  localparam int DEF_DIM_W = 5;
endpackage

// File: rtl/rect_plot_rr_arbiter.sv
// rtl/rect_plot_rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win_oh,
  output logic [IDX_W-1:0]   win_idx
);
  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found        = 1'b1;
        win_oh[cand] = 1'b1;
        win_idx      = cand;
      end
    end
  end
endmodule

// File: rtl/rect_plot_arbiter.sv
// rtl/rect_plot_arbiter.sv - round-robin shared rectangle filler driving a framebuffer write port
module rect_plot_arbiter
  import rect_plot_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int X_W     = DEF_X_W,
  parameter int Y_W     = DEF_Y_W,
  parameter int COL_W   = DEF_COL_W,
  parameter int DIM_W   = DEF_DIM_W
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*X_W-1:0]   req_x,
  input  logic [NUM_REQ*Y_W-1:0]   req_y,
  input  logic [NUM_REQ*DIM_W-1:0] req_w,
  input  logic [NUM_REQ*DIM_W-1:0] req_h,
  input  logic [NUM_REQ*COL_W-1:0] req_colour,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic [X_W-1:0]           x,
  output logic [Y_W-1:0]           y,
  output logic [COL_W-1:0]         colour,
  output logic                     writeEn,
  output logic                     busy
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state, state_nx;
  logic [IDX_W-1:0]   ptr, win, arb_idx;
  logic [NUM_REQ-1:0] arb_oh;
  logic [X_W-1:0]     bx, ld_x;
  logic [Y_W-1:0]     by, ld_y;
  logic [DIM_W-1:0]   bw, bh, cx, cy, ld_w, ld_h;
  logic [COL_W-1:0]   col, ld_col;
  logic [X_W:0]       sum_x;
  logic [Y_W:0]       sum_y;
  logic               scan, last_col, last_row;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req     (req),
    .ptr     (ptr),
    .win_oh  (arb_oh),
    .win_idx (arb_idx)
  );

  assign ld_x   = req_x[int'(win)*X_W +: X_W];
  assign ld_y   = req_y[int'(win)*Y_W +: Y_W];
  assign ld_w   = req_w[int'(win)*DIM_W +: DIM_W];
  assign ld_h   = req_h[int'(win)*DIM_W +: DIM_W];
  assign ld_col = req_colour[int'(win)*COL_W +: COL_W];

  assign last_col = (cx == bw - 1'b1);
  assign last_row = (cy == bh - 1'b1);

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (|arb_oh) state_nx = ST_LOAD;
      ST_LOAD: state_nx = (ld_w == '0 || ld_h == '0) ? ST_DONE : ST_SCAN;
      ST_SCAN: if (last_col && last_row) state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      ptr   <= '0;
      win   <= '0;
      bx    <= '0;
      by    <= '0;
      bw    <= '0;
      bh    <= '0;
      col   <= '0;
      cx    <= '0;
      cy    <= '0;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE: if (|arb_oh) win <= arb_idx;
        ST_LOAD: begin
          bx  <= ld_x;
          by  <= ld_y;
          bw  <= ld_w;
          bh  <= ld_h;
          col <= ld_col;
          cx  <= '0;
          cy  <= '0;
        end
        ST_SCAN: begin
          if (last_col) begin
            cx <= '0;
            cy <= cy + 1'b1;
          end else begin
            cx <= cx + 1'b1;
          end
        end
        // next search starts just above the requester we finished
        ST_DONE: ptr <= (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
        default: ;
      endcase
    end
  end

  // one extra bit so a pixel past the right/bottom edge is detected rather than wrapped
  assign sum_x = {1'b0, bx} + (X_W+1)'(cx);
  assign sum_y = {1'b0, by} + (Y_W+1)'(cy);

  assign scan    = (state == ST_SCAN);
  assign busy    = (state != ST_IDLE);
  assign x       = scan ? sum_x[X_W-1:0] : '0;
  assign y       = scan ? sum_y[Y_W-1:0] : '0;
  assign colour  = scan ? col : '0;
  assign writeEn = scan && (int'(sum_x) < SCREEN_W) && (int'(sum_y) < SCREEN_H);

  always_comb begin
    grant = '0;
    done  = '0;
    if (busy) grant[win] = 1'b1;
    if (state == ST_DONE) done[win] = 1'b1;
  end
endmodule

// File: tb/tb_rect_plot_arbiter.sv
// tb/tb_rect_plot_arbiter.sv - directed bench with a queue-based pixel model of rect_plot_arbiter
module tb_rect_plot_arbiter;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [2:0]  req = '0;
  logic [23:0] req_x = '0;
  logic [20:0] req_y = '0;
  logic [14:0] req_w = '0;
  logic [14:0] req_h = '0;
  logic [8:0]  req_colour = '0;
  logic [2:0]  grant, done;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        writeEn, busy;

  rect_plot_arbiter dut (
    .clk(clk), .resetn(resetn), .req(req), .req_x(req_x), .req_y(req_y),
    .req_w(req_w), .req_h(req_h), .req_colour(req_colour), .grant(grant),
    .done(done), .x(x), .y(y), .colour(colour), .writeEn(writeEn), .busy(busy)
  );

  always #5 clk = ~clk;

  // inputs as seen by the DUT at the most recent rising edge
  logic        s_rstn = 1'b0;
  logic [2:0]  s_req = '0;
  logic [23:0] s_x = '0;
  logic [20:0] s_y = '0;
  logic [14:0] s_w = '0;
  logic [14:0] s_h = '0;
  logic [8:0]  s_c = '0;
  always @(posedge clk) begin
    s_rstn = resetn; s_req = req; s_x = req_x; s_y = req_y;
    s_w = req_w; s_h = req_h; s_c = req_colour;
  end

  typedef struct {
    int g; int d; int x; int y; int c; int we; bit scan;
  } rec_t;

  rec_t mq[$];
  int   m_ptr = 0, m_win = 0;
  bit   m_pend = 0, m_prev_idle = 1, in_rst = 1;
  int   n_tests = 0, n_fail = 0, cyc = 0;
  int   wr_x[$], wr_y[$], done_idx[$], done_cyc[$];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // one clock: advance the model by the edge just taken, then compare every output
  task automatic tick();
    rec_t e, r;
    int bx, by, bw, bh, bc, px, py;
    @(negedge clk);
    cyc++;
    e = '{default: 0};
    if (!s_rstn || !resetn) begin
      mq.delete(); m_ptr = 0; m_pend = 0; m_prev_idle = 1; in_rst = 1;
    end else begin
      in_rst = 0;
      if (m_pend) begin
        m_pend = 0;
        bx = int'(s_x[m_win*8 +: 8]); by = int'(s_y[m_win*7 +: 7]);
        bw = int'(s_w[m_win*5 +: 5]); bh = int'(s_h[m_win*5 +: 5]);
        bc = int'(s_c[m_win*3 +: 3]);
        for (int j = 0; j < bw*bh; j++) begin
          px = bx + j % bw; py = by + j / bw;
          r = '{default: 0};
          r.g = 1 << m_win; r.scan = 1; r.x = px % 256; r.y = py % 128; r.c = bc;
          r.we = (px < 160 && py < 120) ? 1 : 0;
          mq.push_back(r);
        end
        r = '{default: 0}; r.g = 1 << m_win; r.d = 1 << m_win;
        mq.push_back(r);
      end else if (mq.size() == 0 && m_prev_idle && s_req != 0) begin
        for (int k = 2; k >= 0; k--)
          if (s_req[(m_ptr + k) % 3]) m_win = (m_ptr + k) % 3;
        m_ptr = (m_win + 1) % 3;
        r = '{default: 0}; r.g = 1 << m_win;
        mq.push_back(r);
        m_pend = 1;
      end
      if (mq.size() > 0) begin e = mq.pop_front(); m_prev_idle = 0; end
      else m_prev_idle = 1;
    end
    chk("grant", int'(grant), e.g);
    chk("grant_onehot0", int'($onehot0(grant)), 1);
    chk("done", int'(done), e.d);
    chk("writeEn", int'(writeEn), e.we);
    chk("busy", int'(busy), (e.g != 0) ? 1 : 0);
    if (e.scan || in_rst) begin
      chk("x", int'(x), e.x);
      chk("y", int'(y), e.y);
      chk("colour", int'(colour), e.c);
    end
    if (writeEn) begin wr_x.push_back(int'(x)); wr_y.push_back(int'(y)); end
    for (int i = 0; i < 3; i++)
      if (done[i]) begin done_idx.push_back(i); done_cyc.push_back(cyc); end
  endtask

  task automatic set_rect(input int i, input int rx, input int ry, input int rw,
                          input int rh, input int rc);
    req_x[i*8 +: 8] = 8'(rx); req_y[i*7 +: 7] = 7'(ry);
    req_w[i*5 +: 5] = 5'(rw); req_h[i*5 +: 5] = 5'(rh);
    req_colour[i*3 +: 3] = 3'(rc);
  endtask

  task automatic wait_done(input int i, input string name);
    bit seen = 0;
    for (int t = 0; t < 400 && !seen; t++) begin
      tick();
      if (done[i]) seen = 1;
    end
    if (!seen) begin
      n_tests++; n_fail++;
      $display("FAIL %s: done[%0d] not seen within 400 cycles", name, i);
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    tick();
  endtask

  initial begin
    int c0, wb, db;
    bit hit;

    do_reset();
    chk("post_reset_grant", int'(grant), 0);
    chk("post_reset_busy", int'(busy), 0);

    // single 2x2 rectangle
    set_rect(0, 10, 20, 2, 2, 3'b100);
    wb = wr_x.size(); db = done_idx.size(); c0 = cyc;
    req[0] = 1'b1;
    wait_done(0, "single");
    req[0] = 1'b0;
    chk("single_nwrites", wr_x.size() - wb, 4);
    if (wr_x.size() - wb == 4) begin
      chk("single_w0x", wr_x[wb], 10);   chk("single_w0y", wr_y[wb], 20);
      chk("single_w1x", wr_x[wb+1], 11); chk("single_w1y", wr_y[wb+1], 20);
      chk("single_w2x", wr_x[wb+2], 10); chk("single_w2y", wr_y[wb+2], 21);
      chk("single_w3x", wr_x[wb+3], 11); chk("single_w3y", wr_y[wb+3], 21);
    end
    if (done_idx.size() > db) chk("single_done_cycle", done_cyc[db] - c0 + 1, 7);
    repeat (2) tick();

    // contention from a fresh pointer
    do_reset();
    set_rect(0, 1, 1, 1, 1, 1);
    set_rect(1, 2, 2, 2, 1, 2);
    set_rect(2, 3, 3, 1, 2, 3);
    db = done_idx.size();
    req = 3'b111;
    for (int t = 0; t < 200 && done_idx.size() < db + 4; t++) tick();
    req = 3'b000;
    chk("contend_ndone", done_idx.size() - db, 4);
    if (done_idx.size() >= db + 4) begin
      chk("contend_o0", done_idx[db], 0);   chk("contend_o1", done_idx[db+1], 1);
      chk("contend_o2", done_idx[db+2], 2); chk("contend_o3", done_idx[db+3], 0);
    end
    repeat (3) tick();

    // clipping at the bottom-right corner
    set_rect(1, 158, 119, 4, 2, 6);
    wb = wr_x.size(); db = done_idx.size(); c0 = cyc;
    req[1] = 1'b1;
    wait_done(1, "clip");
    req[1] = 1'b0;
    chk("clip_nwrites", wr_x.size() - wb, 2);
    if (wr_x.size() - wb == 2) begin
      chk("clip_w0x", wr_x[wb], 158);   chk("clip_w0y", wr_y[wb], 119);
      chk("clip_w1x", wr_x[wb+1], 159); chk("clip_w1y", wr_y[wb+1], 119);
    end
    if (done_idx.size() > db) chk("clip_done_cycle", done_cyc[db] - c0 + 1, 8 + 3);
    repeat (2) tick();

    // zero width
    set_rect(2, 40, 40, 0, 5, 7);
    wb = wr_x.size(); db = done_idx.size(); c0 = cyc;
    req[2] = 1'b1;
    wait_done(2, "zero");
    req[2] = 1'b0;
    chk("zero_nwrites", wr_x.size() - wb, 0);
    if (done_idx.size() > db) chk("zero_done_cycle", done_cyc[db] - c0 + 1, 3);
    repeat (2) tick();

    // reset in the middle of an 8x8 scan
    set_rect(0, 0, 0, 8, 8, 5);
    wb = wr_x.size(); db = done_idx.size();
    req[0] = 1'b1;
    hit = 0;
    for (int t = 0; t < 200 && !hit; t++) begin
      tick();
      if (wr_x.size() - wb >= 20) hit = 1;
    end
    chk("rst_scan_reached", int'(hit), 1);
    #1 resetn = 1'b0; req = 3'b000;
    #1;
    chk("rst_imm_grant", int'(grant), 0);
    chk("rst_imm_busy", int'(busy), 0);
    chk("rst_imm_we", int'(writeEn), 0);
    chk("rst_imm_xyc", int'(x) + int'(y) + int'(colour) + int'(done), 0);
    repeat (2) tick();
    resetn = 1'b1;
    tick();
    chk("rst_no_done", done_idx.size() - db, 0);
    set_rect(2, 5, 5, 1, 1, 2);
    req[2] = 1'b1;
    wait_done(2, "after_rst");
    req[2] = 1'b0;
    if (done_idx.size() > db) chk("after_rst_first", done_idx[db], 2);
    repeat (2) tick();

    // origin change while scanning must be ignored
    set_rect(0, 30, 40, 3, 2, 5);
    wb = wr_x.size();
    req[0] = 1'b1;
    hit = 0;
    for (int t = 0; t < 50 && !hit; t++) begin
      tick();
      if (wr_x.size() > wb) hit = 1;
    end
    req_x[7:0] = 8'd100;
    wait_done(0, "stable");
    req[0] = 1'b0;
    chk("stable_nwrites", wr_x.size() - wb, 6);
    if (wr_x.size() - wb == 6) begin
      chk("stable_last_x", wr_x[wb+5], 32);
      chk("stable_last_y", wr_y[wb+5], 41);
    end
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
